// File: rtl/board_fetch_arbiter_pkg.sv
// Shared constants for the board fetch arbiter: entity/game codes, board geometry
// and the encodings of the board-RAM port phases.
package board_fetch_arbiter_pkg;

  localparam logic [2:0] ENT_NOTHING  = 3'd0;
  localparam logic [2:0] STATE_START  = 3'd1;
  localparam logic [2:0] STATE_INGAME = 3'd2;

  localparam int BOARD_H_SQUARE = 20;
  localparam int BOARD_V_SQUARE = 20;
  localparam int BOARD_H_TILES  = 32;
  localparam int BOARD_V_TILES  = 24;

  typedef logic [1:0] port_state_t;

  localparam port_state_t PORT_IDLE  = 2'd0;
  localparam port_state_t PORT_READ  = 2'd1;
  localparam port_state_t PORT_CAPT  = 2'd2;
  localparam port_state_t PORT_WRITE = 2'd3;

  // Counter width that never collapses to zero bits for tiny geometries.
  function automatic int clogW(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/board_fetch_arbiter_if.sv
// Board-RAM port plus game-logic write handshake; slave is the arbiter side,
// master is the RAM/game-logic side.
interface board_fetch_arbiter_if
  import board_fetch_arbiter_pkg::*;
#(
  parameter int ADDR_W = 10,
  parameter int ENT_W  = 3
) ();

  logic [ADDR_W-1:0] oRam_addr;
  logic              oRam_we;
  logic [ENT_W-1:0]  oRam_wdata;
  logic [ENT_W-1:0]  iRam_rdata;
  logic              iWr_req;
  logic [ADDR_W-1:0] iWr_addr;
  logic [ENT_W-1:0]  iWr_data;
  logic              oWr_ack;
  logic              oWr_drop;

  modport slave (
    output oRam_addr, oRam_we, oRam_wdata,
    input  iRam_rdata,
    input  iWr_req, iWr_addr, iWr_data,
    output oWr_ack, oWr_drop
  );

  modport master (
    input  oRam_addr, oRam_we, oRam_wdata,
    output iRam_rdata,
    output iWr_req, iWr_addr, iWr_data,
    input  oWr_ack, oWr_drop
  );

endinterface

// File: rtl/board_fetch_arbiter_tile_pos_counter.sv
// Raster-to-tile position counters: pixel-in-tile, column and row of the current
// pixel, plus the row and y of the line that follows.
module tile_pos_counter
  import board_fetch_arbiter_pkg::*;
#(
  parameter int H_SQUARE = BOARD_H_SQUARE,
  parameter int V_SQUARE = BOARD_V_SQUARE,
  parameter int H_TILES  = BOARD_H_TILES,
  parameter int V_TILES  = BOARD_V_TILES,
  parameter int V_TOTAL  = 525,
  parameter int PIX_W    = clogW(H_SQUARE),
  parameter int COL_W    = clogW(H_TILES + 1),
  parameter int LINE_W   = clogW(V_SQUARE),
  parameter int ROW_W    = clogW(V_TILES + 1)
) (
  input  logic             iVGA_CLK,
  input  logic             iReset_n,
  input  logic [9:0]       x_i,
  input  logic [9:0]       y_i,
  output logic [PIX_W-1:0] pix_o,
  output logic [COL_W-1:0] col_o,
  output logic [ROW_W-1:0] row_o,
  output logic [ROW_W-1:0] nextRow_o,
  output logic [9:0]       nextY_o
);

  localparam logic [PIX_W-1:0]  PIX_LAST  = PIX_W'(H_SQUARE - 1);
  localparam logic [LINE_W-1:0] LINE_LAST = LINE_W'(V_SQUARE - 1);
  localparam logic [COL_W-1:0]  COL_SAT   = COL_W'(H_TILES);
  localparam logic [ROW_W-1:0]  ROW_SAT   = ROW_W'(V_TILES);

  logic [PIX_W-1:0]  pix_q,  pix_d;
  logic [COL_W-1:0]  col_q,  col_d;
  logic [LINE_W-1:0] line_q, line_d;
  logic [ROW_W-1:0]  row_q,  row_d;

  // The registers hold the previous pixel's position; the raster advances by one
  // pixel per clock, so the current position is derived from them combinationally.
  always_comb begin
    pix_d  = pix_q;
    col_d  = col_q;
    line_d = line_q;
    row_d  = row_q;
    if (x_i == 10'd0) begin
      pix_d = '0;
      col_d = '0;
      if (y_i == 10'd0) begin
        line_d = '0;
        row_d  = '0;
      end else if (line_q == LINE_LAST) begin
        line_d = '0;
        if (row_q != ROW_SAT) row_d = row_q + 1'b1;
      end else begin
        line_d = line_q + 1'b1;
      end
    end else if (pix_q == PIX_LAST) begin
      pix_d = '0;
      if (col_q != COL_SAT) col_d = col_q + 1'b1;
    end else begin
      pix_d = pix_q + 1'b1;
    end
  end

  always_ff @(posedge iVGA_CLK or negedge iReset_n) begin
    if (!iReset_n) begin
      pix_q  <= '0;
      col_q  <= '0;
      line_q <= '0;
      row_q  <= '0;
    end else begin
      pix_q  <= pix_d;
      col_q  <= col_d;
      line_q <= line_d;
      row_q  <= row_d;
    end
  end

  always_comb begin
    nextY_o   = (y_i == 10'(V_TOTAL - 1)) ? 10'd0 : y_i + 10'd1;
    nextRow_o = row_d;
    if (nextY_o == 10'd0) begin
      nextRow_o = '0;
    end else if (line_d == LINE_LAST && row_d != ROW_SAT) begin
      nextRow_o = row_d + 1'b1;
    end
  end

  assign pix_o = pix_d;
  assign col_o = col_d;
  assign row_o = row_d;

endmodule

// File: rtl/board_fetch_arbiter.sv
// Prefetches board tiles one tile ahead of the VGA raster and shares the single
// board-RAM port between those fetches and game-logic tile writes.
module board_fetch_arbiter
  import board_fetch_arbiter_pkg::*;
#(
  parameter int H_SQUARE = BOARD_H_SQUARE,
  parameter int V_SQUARE = BOARD_V_SQUARE,
  parameter int H_TILES  = BOARD_H_TILES,
  parameter int V_TILES  = BOARD_V_TILES,
  parameter int H_ACTIVE = 640,
  parameter int V_ACTIVE = 480,
  parameter int V_TOTAL  = 525,
  parameter int ADDR_W   = 10,
  parameter int ENT_W    = 3
) (
  input  logic                 iVGA_CLK,
  input  logic                 iReset_n,
  input  logic [9:0]           ivga_x,
  input  logic [9:0]           ivga_y,
  input  logic [2:0]           iGame_state,
  board_fetch_arbiter_if.slave bus,
  output logic [ENT_W-1:0]     oSprite
);

  localparam int PIX_W   = clogW(H_SQUARE);
  localparam int COL_W   = clogW(H_TILES + 1);
  localparam int ROW_W   = clogW(V_TILES + 1);
  localparam int N_TILES = H_TILES * V_TILES;
  localparam logic [ENT_W-1:0] NOTHING = ENT_W'(ENT_NOTHING);

  logic [PIX_W-1:0] pix;
  logic [COL_W-1:0] col;
  logic [ROW_W-1:0] row, nextRow;
  logic [9:0]       nextY;

  tile_pos_counter #(
    .H_SQUARE(H_SQUARE), .V_SQUARE(V_SQUARE), .H_TILES(H_TILES),
    .V_TILES(V_TILES), .V_TOTAL(V_TOTAL)
  ) uPos (
    .iVGA_CLK (iVGA_CLK),
    .iReset_n (iReset_n),
    .x_i      (ivga_x),
    .y_i      (ivga_y),
    .pix_o    (pix),
    .col_o    (col),
    .row_o    (row),
    .nextRow_o(nextRow),
    .nextY_o  (nextY)
  );

  port_state_t       state_q, state_d;
  logic [ADDR_W-1:0] ramAddr_q, ramAddr_d;
  logic [ENT_W-1:0]  ramWdata_q, ramWdata_d;
  logic              ramWe_q, wrAck_q, wrDrop_q;
  logic [ENT_W-1:0]  nextCode_q, nextCode_d, curCode_q, curCode_d, sprite_q, sprite_d;

  logic inGame, hActive, vActive, inLineSlot, lineSlot, fetch, grant, inRange;
  logic [ADDR_W-1:0] fetchAddr;

  always_comb begin
    inGame     = (iGame_state == STATE_INGAME);
    hActive    = (ivga_x < 10'(H_ACTIVE));
    vActive    = (ivga_y < 10'(V_ACTIVE));
    inLineSlot = inGame && vActive && hActive && (pix == PIX_W'(H_SQUARE - 4))
                 && (col < COL_W'(H_TILES - 1));
    lineSlot   = inGame && (ivga_x == 10'(H_ACTIVE)) && (nextY < 10'(V_ACTIVE));
    fetch      = inLineSlot || lineSlot;
    fetchAddr  = inLineSlot ? ADDR_W'(int'(row) * H_TILES + int'(col) + 1)
                            : ADDR_W'(int'(nextRow) * H_TILES);
    inRange    = (int'(bus.iWr_addr) < N_TILES);
    // Masking on the registered ack stops a still-held request being granted twice.
    grant      = !fetch && bus.iWr_req && !wrAck_q;
  end

  always_comb begin
    state_d    = PORT_IDLE;
    ramAddr_d  = ramAddr_q;
    ramWdata_d = ramWdata_q;
    nextCode_d = nextCode_q;
    curCode_d  = curCode_q;
    if (fetch) begin
      state_d   = PORT_READ;
      ramAddr_d = fetchAddr;
    end else if (state_q == PORT_READ) begin
      state_d = PORT_CAPT;
    end else if (grant) begin
      state_d = PORT_WRITE;
    end
    if (grant && inRange) begin
      ramAddr_d  = bus.iWr_addr;
      ramWdata_d = bus.iWr_data;
    end
    if (state_q == PORT_CAPT) nextCode_d = bus.iRam_rdata;
    if (hActive && pix == '0) curCode_d = nextCode_q;
    sprite_d = (inGame && hActive && vActive) ? curCode_d : NOTHING;
  end

  always_ff @(posedge iVGA_CLK or negedge iReset_n) begin
    if (!iReset_n) begin
      state_q    <= PORT_IDLE;
      ramAddr_q  <= '0;
      ramWdata_q <= '0;
      ramWe_q    <= 1'b0;
      wrAck_q    <= 1'b0;
      wrDrop_q   <= 1'b0;
      nextCode_q <= NOTHING;
      curCode_q  <= NOTHING;
      sprite_q   <= NOTHING;
    end else begin
      state_q    <= state_d;
      ramAddr_q  <= ramAddr_d;
      ramWdata_q <= ramWdata_d;
      ramWe_q    <= grant && inRange;
      wrAck_q    <= grant;
      wrDrop_q   <= grant && !inRange;
      nextCode_q <= nextCode_d;
      curCode_q  <= curCode_d;
      sprite_q   <= sprite_d;
    end
  end

  assign bus.oRam_addr  = ramAddr_q;
  assign bus.oRam_we    = ramWe_q;
  assign bus.oRam_wdata = ramWdata_q;
  assign bus.oWr_ack    = wrAck_q;
  assign bus.oWr_drop   = wrDrop_q;
  assign oSprite        = sprite_q;

endmodule
